// File: rtl/sbox_f_unit.sv
// -----------------------------------------------------------------------------
// sbox_f_unit
//
// Purpose:
//   Four writable S-box tables (box0..box3, each 2**ADDR_W x DATA_W) and a
//   two-stage lookup pipeline that computes
//       f_out = ((box0[a] + box1[b]) ^ box2[c]) + box3[d]
//   with all additions modulo 2**DATA_W. A one-cycle clr request sweeps every
//   entry of all four boxes to zero, one entry index per cycle.
//
// Pipeline:
//   S1 registers the four table reads. S2 registers the arithmetic result and
//   drives f_out. Both stages move together on
//   advance = !f_out_valid || f_out_ready.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset (tables are never reset)
//   wr_en        S-box write strobe (honoured only while idle)
//   wr_box       target box 0..3
//   wr_addr      target entry
//   wr_data      entry value
//   clr          one-cycle request to zero all entries (honoured only while idle)
//   busy         high while the clear sweep runs
//   f_in_valid   lookup request valid
//   f_in_ready   lookup request accepted when high together with f_in_valid
//   f_x          F input {a, b, c, d}; a = MSB slice indexes box0
//   f_out_valid  result valid
//   f_out_ready  consumer accepts the result
//   f_out        F result
//
// Build option:
//   SBOX_WR_BYPASS_EN  when defined, a lookup accepted in the same cycle as a
//                      write to the same box/entry returns the new wr_data;
//                      otherwise it returns the entry's value before the write.
// -----------------------------------------------------------------------------
module sbox_f_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [1:0]          wr_box,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                clr,
  output logic                busy,
  input  logic                f_in_valid,
  output logic                f_in_ready,
  input  logic [4*ADDR_W-1:0] f_x,
  output logic                f_out_valid,
  input  logic                f_out_ready,
  output logic [DATA_W-1:0]   f_out
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam logic [ADDR_W-1:0] LAST_ENTRY = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ONE_ENTRY  = {{(ADDR_W-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  logic [0:0]        state_reg;
  logic [0:0]        state_next;
  logic [ADDR_W-1:0] counter_reg;
  logic [ADDR_W-1:0] counter_next;

  logic              clearing;
  logic              advance;
  logic              accept;
  logic              wr_take;

  // Pipeline registers
  logic              s1_valid_reg;
  logic              s2_valid_reg;
  logic [DATA_W-1:0] f_out_reg;

  // Per-box S1 read data, gathered from the generate blocks
  logic [3:0][DATA_W-1:0] s1_data;
  logic [DATA_W-1:0]      f_result;

  assign clearing = (state_reg == ST_CLEAR);

  // Both stages shift together; S2 can only be overwritten once its result
  // has been taken (or if it holds a bubble).
  assign advance    = !s2_valid_reg || f_out_ready;
  assign f_in_ready = !clearing && advance;
  assign accept     = f_in_valid && f_in_ready;

  // A user write lands only while idle, and clr wins over a coincident write.
  assign wr_take = !clearing && wr_en && !clr;

  assign busy        = clearing;
  assign f_out_valid = s2_valid_reg;
  assign f_out       = f_out_reg;

  // ---------------------------------------------------------------------------
  // Clear sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    counter_next = counter_reg;
    case (state_reg)
      ST_IDLE: begin
        if (clr) begin
          state_next   = ST_CLEAR;
          counter_next = '0;
        end
      end
      ST_CLEAR: begin
        // The entry at counter is zeroed this cycle; after the last entry the
        // sweep hands control back to IDLE.
        if (counter_reg == LAST_ENTRY) begin
          state_next   = ST_IDLE;
          counter_next = '0;
        end else begin
          counter_next = counter_reg + ONE_ENTRY;
        end
      end
      default: begin
        state_next   = ST_IDLE;
        counter_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      counter_reg <= '0;
    end else begin
      state_reg   <= state_next;
      counter_reg <= counter_next;
    end
  end

  // ---------------------------------------------------------------------------
  // S-box tables with registered read (S1)
  //
  // Each box has a single write port shared between the clear sweep and user
  // writes (they never coexist: user writes are ignored while clearing) and a
  // single read port whose output register is the S1 data register. The read
  // register only loads on an accepted lookup, so later writes (including
  // those issued while the pipe is stalled) cannot disturb captured data.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 4; gi++) begin : g_box
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_reg;
    logic [ADDR_W-1:0] rd_addr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    // box0 is indexed by the most significant slice of f_x.
    assign rd_addr = f_x[(3-gi)*ADDR_W +: ADDR_W];

    assign mem_we    = clearing || (wr_take && (wr_box == 2'(gi)));
    assign mem_addr  = clearing ? counter_reg : wr_addr;
    assign mem_wdata = clearing ? '0 : wr_data;

    always_ff @(posedge clk) begin
      if (mem_we) begin
        mem[mem_addr] <= mem_wdata;
      end
    end

`ifdef SBOX_WR_BYPASS_EN
    // Same-cycle write to the entry being looked up: forward the new value.
    logic hit;
    assign hit = wr_take && (wr_box == 2'(gi)) && (wr_addr == rd_addr);

    always_ff @(posedge clk) begin
      if (accept) begin
        rd_reg <= hit ? wr_data : mem[rd_addr];
      end
    end
`else
    // Read-before-write: a same-cycle write is not visible to this lookup.
    always_ff @(posedge clk) begin
      if (accept) begin
        rd_reg <= mem[rd_addr];
      end
    end
`endif

    assign s1_data[gi] = rd_reg;
  end

  // ---------------------------------------------------------------------------
  // S2: F arithmetic (all sums wrap at DATA_W bits)
  // ---------------------------------------------------------------------------
  assign f_result = ((s1_data[0] + s1_data[1]) ^ s1_data[2]) + s1_data[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      f_out_reg    <= '0;
    end else if (advance) begin
      // A cycle without an accepted request travels down as a bubble.
      s1_valid_reg <= accept;
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        f_out_reg <= f_result;
      end
    end
  end

endmodule

// File: tb/tb_sbox_f_unit.sv
module tb_sbox_f_unit;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

`ifdef SBOX_WR_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_box = '0;
  logic [7:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        clr = 1'b0;
  logic        busy;
  logic        f_in_valid = 1'b0;
  logic        f_in_ready;
  logic [31:0] f_x = '0;
  logic        f_out_valid;
  logic        f_out_ready = 1'b0;
  logic [31:0] f_out;

  sbox_f_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_box     (wr_box),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .clr        (clr),
    .busy       (busy),
    .f_in_valid (f_in_valid),
    .f_in_ready (f_in_ready),
    .f_x        (f_x),
    .f_out_valid(f_out_valid),
    .f_out_ready(f_out_ready),
    .f_out      (f_out)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference copy of the four tables
  logic [31:0] mdl [4][256];

  typedef struct {
    logic [31:0] fx;
    logic [31:0] v0;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] v3;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual 0x%08h, required 0x%08h", name, act, exp);
  endtask

  // F from the reference tables; an optional same-cycle write is forwarded
  // only when the bypass build is selected.
  function automatic logic [31:0] ref_f(input logic [31:0] fx, input bit we,
                                        input logic [1:0] wbox, input logic [7:0] waddr,
                                        input logic [31:0] wdata);
    logic [31:0] v [4];
    logic [7:0]  idx;
    for (int i = 0; i < 4; i++) begin
      idx  = fx[(3-i)*8 +: 8];
      v[i] = mdl[i][idx];
      if (BYPASS && we && (wbox == 2'(i)) && (waddr == idx)) v[i] = wdata;
    end
    return ((v[0] + v[1]) ^ v[2]) + v[3];
  endfunction

  function automatic void mdl_zero();
    for (int b = 0; b < 4; b++)
      for (int e = 0; e < 256; e++) mdl[b][e] = 32'h0;
  endfunction

  task automatic write_entry(input logic [1:0] box, input logic [7:0] addr, input logic [31:0] data);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_box = box; wr_addr = addr; wr_data = data;
    @(posedge clk); #1;
    wr_en = 1'b0;
    mdl[box][addr] = data;
  endtask

  // Single unstalled lookup; lat counts clock edges from the cycle the
  // request is presented until f_out_valid is observed.
  task automatic do_lookup(input logic [31:0] fx, output logic [31:0] res, output int lat);
    int wait_cnt;
    @(posedge clk); #1;
    f_x = fx; f_in_valid = 1'b1; f_out_ready = 1'b1;
    #1;
    wait_cnt = 0;
    while (!f_in_ready && wait_cnt < 20) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    @(posedge clk); #1;
    f_in_valid = 1'b0;
    lat = 1;
    while (!f_out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    res = f_out;
  endtask

  task automatic lookup_check(input string name, input logic [31:0] fx, input logic [31:0] exp);
    logic [31:0] res;
    int lat;
    do_lookup(fx, res, lat);
    $display("lookup %s f_x=0x%08h f_out=0x%08h exp=0x%08h lat=%0d", name, fx, res, exp, lat);
    check(name, res, exp);
    check({name, "_lat"}, 32'(lat), 32'd2);
  endtask

  // Pulse clr (optionally with a coincident write that must be dropped), then
  // run through the sweep while poking clr/wr_en, which must be ignored.
  task automatic run_clear(input bit with_write, output int busy_cycles, output int ready_seen);
    @(posedge clk); #1;
    clr = 1'b1; f_out_ready = 1'b1;
    if (with_write) begin
      wr_en = 1'b1; wr_box = 2'd1; wr_addr = 8'd7; wr_data = 32'h55;
    end
    @(posedge clk); #1;
    clr = 1'b0; wr_en = 1'b0; f_in_valid = 1'b1; f_x = 32'h0;
    busy_cycles = 0;
    ready_seen  = 0;
    while (busy && busy_cycles < 400) begin
      if (f_in_ready) ready_seen++;
      busy_cycles++;
      @(posedge clk); #1;
      if (busy_cycles == 10) begin
        clr = 1'b1; wr_en = 1'b1; wr_box = 2'd0; wr_addr = 8'd5; wr_data = 32'hDEAD;
      end else begin
        clr = 1'b0; wr_en = 1'b0;
      end
    end
    f_in_valid = 1'b0; clr = 1'b0; wr_en = 1'b0;
    $display("clear with_write=%0d busy_cycles=%0d ready_seen=%0d", with_write, busy_cycles, ready_seen);
    mdl_zero();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [5];
    logic [31:0] stall_req [4];
    logic [31:0] stall_exp [4];
    logic [31:0] stall_out [8];
    logic [31:0] sb_q [$];
    logic [31:0] expv;
    logic [31:0] prev_out;
    logic [31:0] held;
    bit          prev_stall;
    int          ri, oi, bc, rs, n;

    vecs[0] = '{32'h00000000, 32'h00000001, 32'h00000002, 32'h00000004, 32'h00000008, 32'h0000000F};
    vecs[1] = '{32'h01020304, 32'hFFFFFFFF, 32'h00000002, 32'h00000000, 32'hFFFFFFFF, 32'h00000000};
    vecs[2] = '{32'h10203040, 32'h12345678, 32'h11111111, 32'hFFFFFFFF, 32'h00000001, 32'hDCBA9877};
    vecs[3] = '{32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'h0000FFFF, 32'h00010000, 32'h0001FFFF};
    vecs[4] = '{32'h06060606, 32'h00000001, 32'h00000001, 32'h00000003, 32'h7FFFFFFF, 32'h80000000};

    // ---- reset state ----
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(f_out_valid), 32'd0);
    check("rst_f_out", f_out, 32'h0);
    #19 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(f_in_ready), 32'd1);

    // ---- initial clear so every table entry is known ----
    run_clear(1'b0, bc, rs);
    check("clear0_busy_cycles", 32'(bc), 32'd256);
    check("clear0_ready_low", 32'(rs), 32'd0);

    // ---- table-driven F vectors ----
    for (int i = 0; i < 5; i++) begin
      logic [31:0] fx;
      fx = vecs[i].fx;
      write_entry(2'd0, fx[31:24], vecs[i].v0);
      write_entry(2'd1, fx[23:16], vecs[i].v1);
      write_entry(2'd2, fx[15:8],  vecs[i].v2);
      write_entry(2'd3, fx[7:0],   vecs[i].v3);
      lookup_check($sformatf("vec%0d", i), fx, vecs[i].exp);
    end

    // ---- stall: back-to-back requests with f_out_ready low for 5 cycles ----
    for (int i = 0; i < 4; i++) begin
      stall_req[i] = vecs[i].fx;
      stall_exp[i] = ref_f(vecs[i].fx, 1'b0, 2'd0, 8'd0, 32'h0);
    end
    ri = 0; oi = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk); #1;
      f_out_ready = (cyc >= 5);
      f_in_valid  = (ri < 4);
      if (ri < 4) f_x = stall_req[ri];
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        check("stall_in_ready", 32'(f_in_ready), 32'd0);
        check("stall_out_valid", 32'(f_out_valid), 32'd1);
        check("stall_out_hold", f_out, stall_exp[0]);
      end
      if (f_in_valid && f_in_ready) ri++;
      if (f_out_valid && f_out_ready) begin
        if (oi < 8) stall_out[oi] = f_out;
        $display("stall out[%0d] f_out=0x%08h cyc=%0d", oi, f_out, cyc);
        oi++;
      end
    end
    f_in_valid = 1'b0;
    check("stall_out_count", 32'(oi), 32'd4);
    for (int i = 0; i < 4; i++) check($sformatf("stall_out%0d", i), stall_out[i], stall_exp[i]);

    // ---- randomized traffic against the reference model ----
    prev_stall = 1'b0;
    prev_out   = '0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(posedge clk); #1;
      f_in_valid  = ($urandom_range(0, 99) < 60);
      f_x         = {8'($urandom_range(0, 7)), 8'($urandom_range(0, 7)),
                     8'($urandom_range(0, 7)), 8'($urandom_range(0, 7))};
      f_out_ready = ($urandom_range(0, 99) < 60);
      wr_en       = ($urandom_range(0, 99) < 30);
      wr_box      = 2'($urandom_range(0, 3));
      wr_addr     = 8'($urandom_range(0, 7));
      wr_data     = $urandom;
      #1;
      if (prev_stall) begin
        check("rnd_hold_valid", 32'(f_out_valid), 32'd1);
        check("rnd_hold_data", f_out, prev_out);
      end
      if (f_out_valid && f_out_ready) begin
        if (sb_q.size() == 0) begin
          total++;
          $display("FAIL rnd_unexpected: actual 0x%08h, required no output", f_out);
        end else begin
          expv = sb_q.pop_front();
          $display("rnd out f_out=0x%08h exp=0x%08h", f_out, expv);
          check("rnd_result", f_out, expv);
        end
      end
      if (f_in_valid && f_in_ready) sb_q.push_back(ref_f(f_x, wr_en, wr_box, wr_addr, wr_data));
      if (wr_en) mdl[wr_box][wr_addr] = wr_data;
      prev_stall = f_out_valid && !f_out_ready;
      prev_out   = f_out;
    end
    @(posedge clk); #1;
    f_in_valid = 1'b0; wr_en = 1'b0; f_out_ready = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      #1;
      if (f_out_valid) begin
        if (sb_q.size() == 0) begin
          total++;
          $display("FAIL rnd_unexpected: actual 0x%08h, required no output", f_out);
        end else begin
          expv = sb_q.pop_front();
          $display("rnd drain f_out=0x%08h exp=0x%08h", f_out, expv);
          check("rnd_drain", f_out, expv);
        end
      end
      @(posedge clk); #1;
    end
    check("rnd_queue_empty", 32'(sb_q.size()), 32'd0);

    // ---- clear with a coincident write; lookups afterwards return zero ----
    run_clear(1'b1, bc, rs);
    check("clear1_busy_cycles", 32'(bc), 32'd256);
    check("clear1_ready_low", 32'(rs), 32'd0);
    lookup_check("clear_dropped_wr", 32'h00070000, 32'h0);
    lookup_check("clear_ignored_wr", 32'h05000000, 32'h0);
    lookup_check("clear_zero", 32'h03030303, 32'h0);

    // ---- same-cycle write/lookup collision on box2[0] ----
    @(posedge clk); #1;
    wr_en = 1'b1; wr_box = 2'd2; wr_addr = 8'd0; wr_data = 32'h10;
    f_in_valid = 1'b1; f_x = 32'h0; f_out_ready = 1'b1;
    #1;
    check("coll_in_ready", 32'(f_in_ready), 32'd1);
    @(posedge clk); #1;
    wr_en = 1'b0; f_in_valid = 1'b0;
    @(posedge clk); #1;
    $display("collision f_out=0x%08h bypass=%0d", f_out, BYPASS);
    check("coll_valid", 32'(f_out_valid), 32'd1);
    check("coll_result", f_out, BYPASS ? 32'h10 : 32'h0);
    mdl[2][0] = 32'h10;
    lookup_check("coll_after", 32'h0, 32'h10);

    // ---- reset in the middle of a clear ----
    write_entry(2'd3, 8'd50, 32'h33);
    write_entry(2'd3, 8'd200, 32'h77);
    held = ref_f(32'h0, 1'b0, 2'd0, 8'd0, 32'h0);
    @(posedge clk); #1;
    f_x = 32'h0; f_in_valid = 1'b1; f_out_ready = 1'b0;
    @(posedge clk); #1;
    f_in_valid = 1'b0;
    @(posedge clk); #1;
    check("rstclr_pre_valid", 32'(f_out_valid), 32'd1);
    check("rstclr_pre_data", f_out, held);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    check("rstclr_cycles", 32'(n), 32'd100);
    check("rstclr_busy_mid", 32'(busy), 32'd1);
    check("rstclr_out_hold", f_out, held);
    #3 rst_n = 1'b0;
    #1;
    $display("reset mid-clear busy=%0d f_out_valid=%0d f_out=0x%08h", busy, f_out_valid, f_out);
    check("rstclr_busy", 32'(busy), 32'd0);
    check("rstclr_out_valid", 32'(f_out_valid), 32'd0);
    check("rstclr_f_out", f_out, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; f_out_ready = 1'b1;
    #1;
    check("rstclr_in_ready", 32'(f_in_ready), 32'd1);
    @(posedge clk); #1;
    check("rstclr_idle", 32'(busy), 32'd0);
    lookup_check("rstclr_cleared_entry", 32'h00000032, 32'h0);
    lookup_check("rstclr_kept_entry", 32'h000000C8, 32'h77);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sbox_f_unit.md
SBOX_F_UNIT -- requirements
Module: sbox_f_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning the S-box index width (entries per box = 2**ADDR_W).
REQ-002 SHALL have parameter DATA_W, default 32, meaning the S-box entry width and the F output width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port wr_en, input, 1, S-box write strobe.
REQ-006 SHALL have port wr_box, input, 2, target box 0..3.
REQ-007 SHALL have port wr_addr, input, ADDR_W, target entry.
REQ-008 SHALL have port wr_data, input, DATA_W, entry value.
REQ-009 SHALL have port clr, input, 1, one-cycle request to zero all entries.
REQ-010 SHALL have port busy, output, 1, high while clearing.
REQ-011 SHALL have port f_in_valid, input, 1, lookup request valid.
REQ-012 SHALL have port f_in_ready, output, 1, lookup request accepted when high with f_in_valid.
REQ-013 SHALL have port f_x, input, 4*ADDR_W, F input; a=f_x[4*ADDR_W-1:3*ADDR_W] indexes box0, b indexes box1, c indexes box2, d=f_x[ADDR_W-1:0] indexes box3.
REQ-014 SHALL have port f_out_valid, output, 1, result valid.
REQ-015 SHALL have port f_out_ready, input, 1, consumer accepts the result.
REQ-016 SHALL have port f_out, output, DATA_W, the F result.

Function
REQ-017 SHALL hold four writable 2**ADDR_W x DATA_W tables, box0..box3.
REQ-018 SHALL compute f_out = ((box0[a] + box1[b]) ^ box2[c]) + box3[d], with every addition modulo 2**DATA_W and carries discarded.
REQ-019 SHALL use two pipeline stages: S1 registers the four table reads, and S2 registers the arithmetic result; latency is exactly 2 cycles from acceptance to f_out_valid when unstalled.
REQ-020 SHALL use advance = !f_out_valid || f_out_ready; S1 and S2 shall update only when advance is high, and a bubble shall propagate as valid=0.
REQ-021 SHALL drive f_in_ready = (state==IDLE) && advance.
REQ-022 SHALL hold f_out and f_out_valid stable while f_out_valid && !f_out_ready.
REQ-023 SHALL keep S1 captured data unaffected by writes issued after capture, including during a stall.
REQ-024 SHALL implement states IDLE and CLEAR: clr in IDLE goes to CLEAR with counter=0; CLEAR zeroes entry counter in all four boxes each cycle; counter==2**ADDR_W-1 returns to IDLE next cycle.
REQ-025 SHALL assert busy exactly in CLEAR, for 2**ADDR_W cycles.
REQ-026 SHALL ignore wr_en and clr while in CLEAR; lookups already in S1/S2 complete normally using data already captured.
REQ-027 SHALL let wr_en act in IDLE every cycle regardless of lookup traffic; the write takes effect at the clock edge.
REQ-028 SHALL, when clr and wr_en coincide in IDLE, take clr and drop the write.

Reset
REQ-029 SHALL, on rst_n low, immediately force state=IDLE, counter=0, busy=0, S1/S2 valid=0, f_out=0, and f_out_valid=0; f_in_ready shall be 1 after release.
REQ-030 SHALL abort a clear on reset mid-CLEAR, leaving partially cleared tables; table contents are never reset.

Configuration
REQ-031 SHALL, with macro SBOX_WR_BYPASS_EN defined, return wr_data to S1 when a lookup and a write hit the same box/entry in the same accepting cycle.
REQ-032 SHALL, without SBOX_WR_BYPASS_EN, return the pre-write entry in that case.

Verification
REQ-033 SHALL cover basic F: write box0..3[0x00] = 0x1, 0x2, 0x4, 0x8; f_x=0x00000000 -> f_out=0x0000000F two cycles after acceptance.
REQ-034 SHALL cover wrap: box0[0x01]=0xFFFFFFFF, box1[0x02]=0x2, box2[0x03]=0x0, box3[0x04]=0xFFFFFFFF; f_x=0x01020304 -> f_out=0x00000000.
REQ-035 SHALL cover stall: hold f_out_ready=0 for 5 cycles with back-to-back requests -> f_in_ready=0 after the pipe fills, f_out held, and no result lost or duplicated after release.
REQ-036 SHALL cover clear: pulse clr -> busy high for 256 cycles, f_in_ready=0 throughout, and any lookup afterwards returns 0x00000000.
REQ-037 SHALL cover collision: same-cycle write box2[0x00]=0x10 with lookup f_x=0 (others 0, old box2[0]=0x0) -> 0x10 with SBOX_WR_BYPASS_EN, 0x0 without.
REQ-038 SHALL cover reset mid-clear: rst_n low at clear cycle 100 -> busy=0 and f_out_valid=0 immediately, and IDLE on release.
